// File: rtl/sp_align_pkg.sv
// Shared definitions for the serial-to-parallel comma aligner.
//   state_e          : aligner FSM states (hunt / check / locked)
//   K28_5_RDN/RDP    : K28.5 comma in both running disparities, bit 0 first on the wire
//   CTR_W            : width of the saturating good/err counters (holds 1..15)
//   cnt_w()          : width of the bit-position counter for a given word width
package sp_align_pkg;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_CHECK  = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  localparam logic [9:0] K28_5_RDN = 10'b0101111100;
  localparam logic [9:0] K28_5_RDP = 10'b1010000011;

  localparam int CTR_W = 4;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational comma matcher.
//   win     : current WIDTH-bit window of the serial stream
//   pattern : comma pattern in one disparity
//   hit     : window equals the pattern or its complement (either disparity)
module comma_detect #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] win,
  input  logic [WIDTH-1:0] pattern,
  output logic             hit
);

  assign hit = (win == pattern) || (win == ~pattern);

endmodule

// File: rtl/serial_parallel_align.sv
// Serial-to-parallel converter with comma-based word alignment.
// Bits shift in LSB first; a comma found in HUNT fixes the word boundary,
// ACQ_COMMAS boundary-aligned commas declare lock, and MISALIGN_MAX
// consecutive off-boundary commas drop back to HUNT.
//   CLOCK    : single clock, all state on posedge
//   RESET_L  : asynchronous active-low reset
//   IS       : serial input, first bit of a word first
//   OP       : aligned parallel word (registered, holds outside lock)
//   OP_VALID : one-cycle strobe per word boundary while locked
//   IS_COMMA : OP is a comma (either disparity)
//   LOCKED   : high while the FSM is in the locked state
module serial_parallel_align
  import sp_align_pkg::*;
#(
  parameter int               WIDTH        = 10,
  parameter logic [WIDTH-1:0] COMMA        = WIDTH'(K28_5_RDN),
  parameter int               ACQ_COMMAS   = 3,
  parameter int               MISALIGN_MAX = 2
) (
  input  logic             CLOCK,
  input  logic             RESET_L,
  input  logic             IS,
  output logic [WIDTH-1:0] OP,
  output logic             OP_VALID,
  output logic             IS_COMMA,
  output logic             LOCKED
);

  localparam int               CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CTR_W-1:0] ACQ_N    = CTR_W'(ACQ_COMMAS);
  localparam logic [CTR_W-1:0] MIS_N    = CTR_W'(MISALIGN_MAX);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CTR_W-1:0] good_q, good_d, err_q, err_d;
  logic [CTR_W-1:0] good_inc, err_inc;
  logic [WIDTH-1:0] op_d;
  logic             opv_d, isc_d, lock_d;
  logic             hit, bnd;

  // Detection looks at the window as it will be after this edge's shift.
  assign sr_d = {IS, sr_q[WIDTH-1:1]};

  comma_detect #(.WIDTH(WIDTH)) u_det (
    .win     (sr_d),
    .pattern (COMMA),
    .hit     (hit)
  );

  assign bnd      = (cnt_q == CNT_LAST);
  assign good_inc = (good_q == CTR_MAX) ? good_q : good_q + CTR_W'(1);
  assign err_inc  = (err_q  == CTR_MAX) ? err_q  : err_q  + CTR_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = bnd ? '0 : cnt_q + CW'(1);
    good_d  = good_q;
    err_d   = err_q;
    op_d    = OP;
    opv_d   = 1'b0;
    isc_d   = IS_COMMA;

    unique case (state_q)
      S_HUNT: begin
        if (hit) begin
          cnt_d  = '0;
          good_d = CTR_W'(1);
          if (ACQ_COMMAS == 1) begin
            state_d = S_LOCKED;
            err_d   = '0;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (hit) begin
          if (bnd) begin
            good_d = good_inc;
            if (good_inc == ACQ_N) begin
              state_d = S_LOCKED;
              err_d   = '0;
            end
          end else begin
            cnt_d  = '0;
            good_d = CTR_W'(1);
          end
        end
      end
      S_LOCKED: begin
        if (hit) begin
          if (bnd) begin
            err_d = '0;
          end else begin
            err_d = err_inc;
            // Drop to HUNT without realigning; the next hit restarts search.
            if (err_inc == MIS_N) state_d = S_HUNT;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

    // Emit on every locked boundary, including the one that establishes
    // lock; a direct HUNT->LOCKED hit is itself a forced boundary.
    if (state_d == S_LOCKED && (bnd || state_q == S_HUNT)) begin
      op_d  = sr_d;
      isc_d = hit;
      opv_d = 1'b1;
    end

    lock_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q  <= S_HUNT;
      sr_q     <= '0;
      cnt_q    <= '0;
      good_q   <= '0;
      err_q    <= '0;
      OP       <= '0;
      OP_VALID <= 1'b0;
      IS_COMMA <= 1'b0;
      LOCKED   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      err_q    <= err_d;
      OP       <= op_d;
      OP_VALID <= opv_d;
      IS_COMMA <= isc_d;
      LOCKED   <= lock_d;
    end
  end

endmodule

// File: tb/tb_serial_parallel_align.sv
// Directed bench for serial_parallel_align: default 10-bit K28.5 instance
// plus an 8-bit, single-comma-lock instance.
module tb_serial_parallel_align;

  localparam logic [9:0] KN = 10'h17C;
  localparam logic [9:0] KP = 10'h283;
  localparam logic [9:0] D1 = 10'h155;
  localparam logic [9:0] D2 = 10'h2AA;

  logic       CLOCK   = 1'b0;
  logic       RESET_L = 1'b0;
  logic       is10    = 1'b0;
  logic       is8     = 1'b0;
  logic [9:0] op10;
  logic       v10, c10, l10;
  logic [7:0] op8;
  logic       v8, c8, l8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLOCK = ~CLOCK;

  serial_parallel_align dut (
    .CLOCK    (CLOCK),
    .RESET_L  (RESET_L),
    .IS       (is10),
    .OP       (op10),
    .OP_VALID (v10),
    .IS_COMMA (c10),
    .LOCKED   (l10)
  );

  serial_parallel_align #(
    .WIDTH        (8),
    .COMMA        (8'h3C),
    .ACQ_COMMAS   (1),
    .MISALIGN_MAX (2)
  ) dut8 (
    .CLOCK    (CLOCK),
    .RESET_L  (RESET_L),
    .IS       (is8),
    .OP       (op8),
    .OP_VALID (v8),
    .IS_COMMA (c8),
    .LOCKED   (l8)
  );

  typedef struct packed {
    logic       rst;   // reset + 7-bit offset prefix before this word
    logic [9:0] word;
    logic       opv;
    logic [9:0] op;
    logic       isc;
    logic       lck;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Shift n bits LSB first into the selected instance; outputs are sampled
  // 1 time unit after each edge. 'early' counts strobes before the last bit.
  task automatic send(input logic [31:0] bits, input int n, input bit w8, output int early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      if (w8) is8 = bits[i];
      else    is10 = bits[i];
      @(posedge CLOCK);
      #1;
      if (i < n - 1 && (w8 ? v8 : v10)) early++;
    end
  endtask

  task automatic do_reset();
    RESET_L = 1'b0;
    #3;
    RESET_L = 1'b1;
  endtask

  initial begin
    int early;
    int strobes;

    // rst, word, opv, op, isc, lck
    tbl[0]  = '{1'b1, KN, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, KN, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, KN, 1'b1, KN,      1'b1, 1'b1};
    tbl[3]  = '{1'b0, D1, 1'b1, D1,      1'b0, 1'b1};
    tbl[4]  = '{1'b0, KP, 1'b1, KP,      1'b1, 1'b1};
    tbl[5]  = '{1'b0, D2, 1'b1, D2,      1'b0, 1'b1};
    tbl[6]  = '{1'b1, KP, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, D1, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, KN, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, D2, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, KP, 1'b1, KP,      1'b1, 1'b1};
    tbl[11] = '{1'b0, KN, 1'b1, KN,      1'b1, 1'b1};

    // Reset state, before any clock edge.
    #2;
    chk("rst op",     {22'd0, op10}, 32'h0);
    chk("rst opv",    {31'd0, v10},  32'h0);
    chk("rst isc",    {31'd0, c10},  32'h0);
    chk("rst locked", {31'd0, l10},  32'h0);
    chk("rst locked8", {31'd0, l8},  32'h0);
    @(posedge CLOCK);
    #1;
    RESET_L = 1'b1;

    // Acquisition, data in lock, disparity, data between commas in CHECK.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) begin
        do_reset();
        send(32'h55, 7, 1'b0, early);
      end
      send({22'd0, tbl[i].word}, 10, 1'b0, early);
      chk($sformatf("vec%0d early", i), early, 32'd0);
      chk($sformatf("vec%0d opv", i), {31'd0, v10}, {31'd0, tbl[i].opv});
      chk($sformatf("vec%0d op", i), {22'd0, op10}, {22'd0, tbl[i].op});
      chk($sformatf("vec%0d isc", i), {31'd0, c10}, {31'd0, tbl[i].isc});
      chk($sformatf("vec%0d locked", i), {31'd0, l10}, {31'd0, tbl[i].lck});
    end

    // Realign in CHECK: two commas, one shifted by 3, then two more at new phase.
    do_reset();
    send(32'h55, 7, 1'b0, early);
    send({22'd0, KN}, 10, 1'b0, early);
    send({22'd0, KN}, 10, 1'b0, early);
    send(32'h5, 3, 1'b0, early);
    send({22'd0, KN}, 10, 1'b0, early);
    chk("realign shifted locked", {31'd0, l10}, 32'h0);
    send({22'd0, KN}, 10, 1'b0, early);
    chk("realign 2nd locked", {31'd0, l10}, 32'h0);
    chk("realign 2nd opv", {31'd0, v10}, 32'h0);
    send({22'd0, KN}, 10, 1'b0, early);
    chk("realign 3rd locked", {31'd0, l10}, 32'h1);
    chk("realign 3rd opv", {31'd0, v10}, 32'h1);
    chk("realign 3rd op", {22'd0, op10}, {22'd0, KN});

    // Asynchronous reset mid-word while locked.
    send({22'd0, KN}, 4, 1'b0, early);
    #2;
    RESET_L = 1'b0;
    #1;
    chk("async rst op",     {22'd0, op10}, 32'h0);
    chk("async rst isc",    {31'd0, c10},  32'h0);
    chk("async rst locked", {31'd0, l10},  32'h0);
    chk("async rst opv",    {31'd0, v10},  32'h0);
    RESET_L = 1'b1;
    strobes = 0;
    send({22'd0, KN}, 10, 1'b0, early);
    strobes += early + int'(v10);
    send({22'd0, KN}, 10, 1'b0, early);
    strobes += early + int'(v10);
    send({22'd0, KN}, 10, 1'b0, early);
    strobes += early;
    chk("post rst strobes", strobes, 32'd0);
    chk("post rst 3rd opv", {31'd0, v10}, 32'h1);
    chk("post rst 3rd locked", {31'd0, l10}, 32'h1);

    // Off-boundary comma, then aligned comma: err cleared, lock kept.
    send(32'h5, 4, 1'b0, early);
    send({22'd0, KN}, 10, 1'b0, early);
    chk("one off locked", {31'd0, l10}, 32'h1);
    send(32'h15, 6, 1'b0, early);
    send({22'd0, KN}, 10, 1'b0, early);
    chk("realigned early", early, 32'd0);
    chk("realigned opv", {31'd0, v10}, 32'h1);
    chk("realigned op", {22'd0, op10}, {22'd0, KN});
    chk("realigned isc", {31'd0, c10}, 32'h1);
    send(32'h5, 4, 1'b0, early);
    send({22'd0, KN}, 10, 1'b0, early);
    chk("off after clear locked", {31'd0, l10}, 32'h1);
    // Second consecutive off-boundary comma at +4: lock lost.
    send({22'd0, KN}, 10, 1'b0, early);
    chk("loss locked", {31'd0, l10}, 32'h0);
    send(32'h15555555, 30, 1'b0, early);
    chk("hunt strobes", early + int'(v10), 32'd0);
    chk("hunt locked", {31'd0, l10}, 32'h0);
    send({22'd0, KN}, 10, 1'b0, early);
    send({22'd0, KN}, 10, 1'b0, early);
    chk("reacq 2nd locked", {31'd0, l10}, 32'h0);
    send({22'd0, KN}, 10, 1'b0, early);
    chk("reacq opv", {31'd0, v10}, 32'h1);
    chk("reacq op", {22'd0, op10}, {22'd0, KN});

    // WIDTH = 8, single-comma lock, 8-cycle strobe spacing.
    do_reset();
    send(32'h5, 3, 1'b1, early);
    send(32'h3C, 8, 1'b1, early);
    chk("w8 first opv", {31'd0, v8}, 32'h1);
    chk("w8 first op", {24'd0, op8}, 32'h3C);
    chk("w8 first isc", {31'd0, c8}, 32'h1);
    chk("w8 first locked", {31'd0, l8}, 32'h1);
    send(32'h55, 8, 1'b1, early);
    chk("w8 data early", early, 32'd0);
    chk("w8 data opv", {31'd0, v8}, 32'h1);
    chk("w8 data op", {24'd0, op8}, 32'h55);
    chk("w8 data isc", {31'd0, c8}, 32'h0);
    send(32'h3C, 8, 1'b1, early);
    chk("w8 comma early", early, 32'd0);
    chk("w8 comma opv", {31'd0, v8}, 32'h1);
    chk("w8 comma op", {24'd0, op8}, 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
